smart_home_ctrl_p: RTL and testbench
====================================

SMART_HOME_CTRL_P -- requirements
Module: smart_home_ctrl_p

Interface
REQ-001 Parameter N_WIN, default 4, number of window sensors; legal range 1..8.
REQ-002 Parameter TEMP_W, default 7, temperature sample width in bits.
REQ-003 Parameter HEAT_ON, default 50, heating request threshold.
REQ-004 Parameter COOL_ON, default 70, cooling request threshold.
REQ-005 Parameter HYST, default 3, hysteresis band; HEAT_ON+HYST < COOL_ON-HYST is required.
REQ-006 Parameter ALARM_HOLD, default 16, alarm hold time in cycles after SFA falls; range 1..255.
REQ-007 Clk  in  1  single clock; all state changes on its rising edge.
REQ-008 Rst  in  1  reset, asynchronous and active-low.
REQ-009 SFD  in  1  front door sensor, 1 = open.
REQ-010 SRD  in  1  rear door sensor, 1 = open.
REQ-011 SW  in  N_WIN  window sensors, bit i = window i open.
REQ-012 SFA  in  1  fire alarm sensor, 1 = fire.
REQ-013 ST  in  TEMP_W  unsigned temperature sample.
REQ-014 fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler  out  1 each  actuator enables.
REQ-015 win_id  out  max(1,$clog2(N_WIN))  index of the lowest-numbered open window.
REQ-016 display  out  3  current state code.

Function
REQ-017 States and display codes: IDLE=0, FDOOR=1, RDOOR=2, WIN=3, ALARM=4, HEAT=5, COOL=6; code 7 is unused and recovers to IDLE on the next edge.
REQ-018 Next-state priority, evaluated every edge: ALARM condition > SFD > SRD > |SW > heat request > cool request > IDLE.
REQ-019 ALARM condition: SFA=1, or current state is ALARM with hold counter > 0.
REQ-020 Hold counter (8 bits): loads ALARM_HOLD while SFA=1; decrements by 1 per cycle in ALARM with SFA=0; saturates at 0; ALARM exits on the edge after the counter reaches 0, so ALARM persists ALARM_HOLD cycles after SFA falls.
REQ-021 SFA reasserting during the hold reloads the counter; there is no early exit.
REQ-022 Register temp_mode {OFF, HEAT, COOL} updates every cycle regardless of the current state.
- OFF->HEAT when ST < HEAT_ON.
- OFF->COOL when ST > COOL_ON.
- HEAT->OFF when ST >= HEAT_ON+HYST.
- COOL->OFF when ST <= COOL_ON-HYST.
REQ-023 Heat request = temp_mode is HEAT; cool request = temp_mode is COOL.
REQ-024 All outputs decode from registered state only, with no combinational input-to-output path; latency is one edge from input to output.
REQ-025 Output decode per state:
- fdoor = (FDOOR), rdoor = (RDOOR), winbuzz = (WIN), alarmbuzz = (ALARM), heater = (HEAT), cooler = (COOL).
- Outputs are mutually exclusive.
REQ-026 win_id is registered on entry to WIN and on every cycle in WIN; it holds its value outside WIN; it is 0 after reset.
REQ-027 Simultaneous events resolve strictly by REQ-018; a lower-priority source still active when a higher one clears is served on the next edge.
REQ-028 Comparisons are unsigned at TEMP_W width; thresholds are truncated to TEMP_W.

Reset
REQ-029 Rst=0 immediately forces: state IDLE, display 0, every actuator output 0, win_id 0, hold counter 0, temp_mode OFF.
REQ-030 Reset asserted mid-ALARM or mid-HEAT aborts it; after release, behaviour re-derives from inputs starting at the first edge.

Configuration
REQ-031 Macro SHC_HYSTERESIS_EN.
- Defined: the REQ-022 hysteresis applies.
- Undefined: HYST is treated as 0, so temp_mode is combinationally equivalent to the thresholds, registered once; HEAT->OFF at ST >= HEAT_ON, COOL->OFF at ST <= COOL_ON.

Verification
REQ-032 Reset, then all sensors 0 and ST=60 -> display 0, all outputs 0.
REQ-033 SFD=1 and SRD=1 together -> display 1, fdoor=1; then SFD=0 -> next edge display 2, rdoor=1.
REQ-034 N_WIN=4, SW=4'b1100 -> display 3, winbuzz=1, win_id=2; SFA pulsed for 1 cycle -> alarmbuzz=1 for 1+16 cycles, then WIN resumes.
REQ-035 ST sequence 48, 51, 52, 53 -> heater 1, 1, 1, 0 with the macro defined; heater 1, 0, 0, 0 with the macro undefined.
REQ-036 ST=75 (COOL), then SFD=1 for 3 cycles, with ST=75 held -> FDOOR for 3 cycles, then COOL resumes with cooler=1.
REQ-037 Rst driven low between edges during ALARM -> all outputs 0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/smart_home_ctrl_p.sv
// Smart-home controller: prioritised door/window/fire/climate FSM with registered actuator outputs.
// Optional macro SHC_HYSTERESIS_EN enables the hysteresis band on the heating/cooling mode register.
module smart_home_ctrl_p #(
    parameter int N_WIN      = 4,
    parameter int TEMP_W     = 7,
    parameter int HEAT_ON    = 50,
    parameter int COOL_ON    = 70,
    parameter int HYST       = 3,
    parameter int ALARM_HOLD = 16,
    localparam int WID_W     = (N_WIN > 1) ? $clog2(N_WIN) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sfd_i,
    input  logic              srd_i,
    input  logic [N_WIN-1:0]  sw_i,
    input  logic              sfa_i,
    input  logic [TEMP_W-1:0] st_i,
    output logic              fdoor_o,
    output logic              rdoor_o,
    output logic              winbuzz_o,
    output logic              alarmbuzz_o,
    output logic              heater_o,
    output logic              cooler_o,
    output logic [WID_W-1:0]  win_id_o,
    output logic [2:0]        display_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FDOOR = 3'd1,
        S_RDOOR = 3'd2,
        S_WIN   = 3'd3,
        S_ALARM = 3'd4,
        S_HEAT  = 3'd5,
        S_COOL  = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        TM_OFF  = 2'd0,
        TM_HEAT = 2'd1,
        TM_COOL = 2'd2
    } tmode_e;

`ifdef SHC_HYSTERESIS_EN
    localparam int HYST_EFF = HYST;
`else
    localparam int HYST_EFF = 0 * HYST;
`endif

    // Thresholds are truncated to the sample width so all compares stay unsigned at TEMP_W.
    localparam logic [TEMP_W-1:0] HEAT_LO  = TEMP_W'(HEAT_ON);
    localparam logic [TEMP_W-1:0] COOL_HI  = TEMP_W'(COOL_ON);
    localparam logic [TEMP_W-1:0] HEAT_OFF = TEMP_W'(HEAT_ON + HYST_EFF);
    localparam logic [TEMP_W-1:0] COOL_OFF = TEMP_W'(COOL_ON - HYST_EFF);
    localparam logic [7:0]        HOLD_LD  = 8'(ALARM_HOLD);

    state_e             state_q, state_d;
    tmode_e             tmode_q, tmode_d;
    logic [7:0]         hold_q, hold_d;
    logic [WID_W-1:0]   win_id_q, win_id_d;
    logic [WID_W-1:0]   win_idx_s;
    logic               alarm_s;
    logic               state_ok_s;
    logic               fdoor_q, rdoor_q, winbuzz_q, alarmbuzz_q, heater_q, cooler_q;

    // Climate mode: hysteretic tracking of the temperature sample.
    always_comb begin
        tmode_d = TM_OFF;
`ifdef SHC_HYSTERESIS_EN
        case (tmode_q)
            TM_OFF: begin
                if (st_i < HEAT_LO) begin
                    tmode_d = TM_HEAT;
                end else if (st_i > COOL_HI) begin
                    tmode_d = TM_COOL;
                end else begin
                    tmode_d = TM_OFF;
                end
            end
            TM_HEAT: begin
                if (st_i >= HEAT_OFF) begin
                    tmode_d = TM_OFF;
                end else begin
                    tmode_d = TM_HEAT;
                end
            end
            TM_COOL: begin
                if (st_i <= COOL_OFF) begin
                    tmode_d = TM_OFF;
                end else begin
                    tmode_d = TM_COOL;
                end
            end
            default: tmode_d = TM_OFF;
        endcase
`else
        // With a zero band the hold terms collapse onto the entry thresholds.
        if ((st_i < HEAT_LO) || ((tmode_q == TM_HEAT) && (st_i < HEAT_OFF))) begin
            tmode_d = TM_HEAT;
        end else if ((st_i > COOL_HI) || ((tmode_q == TM_COOL) && (st_i > COOL_OFF))) begin
            tmode_d = TM_COOL;
        end else begin
            tmode_d = TM_OFF;
        end
`endif
    end

    // Lowest-numbered open window.
    always_comb begin
        win_idx_s = {WID_W{1'b0}};
        for (int i = N_WIN - 1; i >= 0; i--) begin
            win_idx_s = sw_i[i] ? WID_W'(i) : win_idx_s;
        end
    end

    // Alarm hold counter: reload on fire, count down while holding in ALARM.
    always_comb begin
        hold_d = hold_q;
        if (sfa_i) begin
            hold_d = HOLD_LD;
        end else if ((state_q == S_ALARM) && (hold_q != 8'd0)) begin
            hold_d = hold_q - 8'd1;
        end else begin
            hold_d = hold_q;
        end
    end

    // Next-state selection in fixed priority order; illegal code recovers to IDLE.
    always_comb begin
        state_ok_s = 1'b0;
        alarm_s    = sfa_i || ((state_q == S_ALARM) && (hold_q != 8'd0));
        state_d    = S_IDLE;
        case (state_q)
            S_IDLE, S_FDOOR, S_RDOOR, S_WIN,
            S_ALARM, S_HEAT, S_COOL: state_ok_s = 1'b1;
            default:                 state_ok_s = 1'b0;
        endcase
        if (!state_ok_s) begin
            state_d = S_IDLE;
        end else if (alarm_s) begin
            state_d = S_ALARM;
        end else if (sfd_i) begin
            state_d = S_FDOOR;
        end else if (srd_i) begin
            state_d = S_RDOOR;
        end else if (|sw_i) begin
            state_d = S_WIN;
        end else if (tmode_d == TM_HEAT) begin
            state_d = S_HEAT;
        end else if (tmode_d == TM_COOL) begin
            state_d = S_COOL;
        end else begin
            state_d = S_IDLE;
        end
    end

    // Window index is sampled only while WIN is (or becomes) the active state.
    always_comb begin
        win_id_d = win_id_q;
        if (state_d == S_WIN) begin
            win_id_d = win_idx_s;
        end else begin
            win_id_d = win_id_q;
        end
    end

    // State, counters and actuator registers; outputs decode from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tmode_q     <= TM_OFF;
            hold_q      <= 8'd0;
            win_id_q    <= {WID_W{1'b0}};
            fdoor_q     <= 1'b0;
            rdoor_q     <= 1'b0;
            winbuzz_q   <= 1'b0;
            alarmbuzz_q <= 1'b0;
            heater_q    <= 1'b0;
            cooler_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmode_q     <= tmode_d;
            hold_q      <= hold_d;
            win_id_q    <= win_id_d;
            fdoor_q     <= (state_d == S_FDOOR);
            rdoor_q     <= (state_d == S_RDOOR);
            winbuzz_q   <= (state_d == S_WIN);
            alarmbuzz_q <= (state_d == S_ALARM);
            heater_q    <= (state_d == S_HEAT);
            cooler_q    <= (state_d == S_COOL);
        end
    end

    assign fdoor_o     = fdoor_q;
    assign rdoor_o     = rdoor_q;
    assign winbuzz_o   = winbuzz_q;
    assign alarmbuzz_o = alarmbuzz_q;
    assign heater_o    = heater_q;
    assign cooler_o    = cooler_q;
    assign win_id_o    = win_id_q;
    assign display_o   = state_q;

endmodule

// File: tb/tb_smart_home_ctrl_p.sv
// Directed bench for smart_home_ctrl_p: vector table plus hand-written alarm, climate and reset sequences.
module tb_smart_home_ctrl_p;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sfd, srd, sfa;
    logic [3:0] sw;
    logic [6:0] st;
    logic       fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler;
    logic [1:0] win_id;
    logic [2:0] display;

    int checks   = 0;
    int failures = 0;

    localparam logic [5:0] O_NONE  = 6'b000000;
    localparam logic [5:0] O_FDOOR = 6'b100000;
    localparam logic [5:0] O_RDOOR = 6'b010000;
    localparam logic [5:0] O_WIN   = 6'b001000;
    localparam logic [5:0] O_ALARM = 6'b000100;
    localparam logic [5:0] O_HEAT  = 6'b000010;
    localparam logic [5:0] O_COOL  = 6'b000001;

    typedef struct {
        logic       sfd;
        logic       srd;
        logic       sfa;
        logic [3:0] sw;
        logic [6:0] st;
        logic [2:0] disp;
        logic [5:0] outs;
        logic [1:0] wid;
    } vec_t;

    vec_t vecs[13];

    smart_home_ctrl_p dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sfd_i       (sfd),
        .srd_i       (srd),
        .sw_i        (sw),
        .sfa_i       (sfa),
        .st_i        (st),
        .fdoor_o     (fdoor),
        .rdoor_o     (rdoor),
        .winbuzz_o   (winbuzz),
        .alarmbuzz_o (alarmbuzz),
        .heater_o    (heater),
        .cooler_o    (cooler),
        .win_id_o    (win_id),
        .display_o   (display)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic fd, input logic rd, input logic fa,
                         input logic [3:0] w, input logic [6:0] t);
        sfd = fd;
        srd = rd;
        sfa = fa;
        sw  = w;
        st  = t;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] edisp,
                         input logic [5:0] eout, input logic [1:0] ewid);
        logic [5:0] aout;
        aout = {fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler};
        checks++;
        if ((display !== edisp) || (aout !== eout) || (win_id !== ewid)) begin
            failures++;
            $display("FAIL %s: got display=%0d outs=%b win_id=%0d, expected display=%0d outs=%b win_id=%0d",
                     name, display, aout, win_id, edisp, eout, ewid);
        end
    endtask

    initial begin
        logic [5:0] exp_h;
        logic [2:0] exp_d;

        vecs[0]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 7'd60, 3'd0, O_NONE,  2'd0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 4'b0000, 7'd60, 3'd1, O_FDOOR, 2'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 7'd60, 3'd2, O_RDOOR, 2'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'b1100, 7'd60, 3'd3, O_WIN,   2'd2};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'b1010, 7'd60, 3'd3, O_WIN,   2'd1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 7'd48, 3'd5, O_HEAT,  2'd1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 7'd60, 3'd0, O_NONE,  2'd1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 7'd75, 3'd6, O_COOL,  2'd1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 7'd75, 3'd1, O_FDOOR, 2'd1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 4'b1000, 7'd75, 3'd3, O_WIN,   2'd3};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 4'b1000, 7'd75, 3'd4, O_ALARM, 2'd3};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 4'b0000, 7'd60, 3'd4, O_ALARM, 2'd3};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 4'b0110, 7'd48, 3'd4, O_ALARM, 2'd3};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 7'd60);
        #12;
        check("reset_state", 3'd0, O_NONE, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].sfd, vecs[i].srd, vecs[i].sfa, vecs[i].sw, vecs[i].st);
            step();
            check($sformatf("vec%0d", i), vecs[i].disp, vecs[i].outs, vecs[i].wid);
        end

        // Alarm drains with lower-priority sources pending behind it.
        drive(1'b0, 1'b1, 1'b0, 4'b0110, 7'd60);
        for (int i = 0; i < 14; i++) begin
            step();
            check($sformatf("drain_alarm%0d", i), 3'd4, O_ALARM, 2'd3);
        end
        step();
        check("drain_rdoor", 3'd2, O_RDOOR, 2'd3);
        drive(1'b0, 1'b0, 1'b0, 4'b0110, 7'd60);
        step();
        check("drain_win", 3'd3, O_WIN, 2'd1);
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 7'd60);
        step();
        check("drain_idle", 3'd0, O_NONE, 2'd1);

        // One-cycle fire pulse over an open window: 1 + 16 alarm cycles, then WIN resumes.
        drive(1'b0, 1'b0, 1'b0, 4'b1100, 7'd60);
        step();
        check("pulse_win", 3'd3, O_WIN, 2'd2);
        sfa = 1'b1;
        step();
        check("pulse_alarm", 3'd4, O_ALARM, 2'd2);
        sfa = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            check($sformatf("pulse_hold%0d", i), 3'd4, O_ALARM, 2'd2);
        end
        step();
        check("pulse_resume", 3'd3, O_WIN, 2'd2);

        // Fire reasserting mid-hold reloads the full hold time.
        drive(1'b0, 1'b0, 1'b1, 4'b0000, 7'd60);
        step();
        check("reload_first", 3'd4, O_ALARM, 2'd2);
        sfa = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("reload_pre%0d", i), 3'd4, O_ALARM, 2'd2);
        end
        sfa = 1'b1;
        step();
        check("reload_again", 3'd4, O_ALARM, 2'd2);
        sfa = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            check($sformatf("reload_hold%0d", i), 3'd4, O_ALARM, 2'd2);
        end
        step();
        check("reload_exit", 3'd0, O_NONE, 2'd2);

        // Heating hysteresis: ST 48, 51, 52, 53.
        for (int i = 0; i < 4; i++) begin
            st = (i == 0) ? 7'd48 : 7'(7'd50 + 7'(i));
            step();
`ifdef SHC_HYSTERESIS_EN
            exp_h = (i < 3) ? O_HEAT : O_NONE;
`else
            exp_h = (i < 1) ? O_HEAT : O_NONE;
`endif
            exp_d = (exp_h == O_HEAT) ? 3'd5 : 3'd0;
            check($sformatf("heat_seq%0d", i), exp_d, exp_h, 2'd2);
        end
        st = 7'd60;
        step();
        check("heat_off", 3'd0, O_NONE, 2'd2);

        // Cooling preempted by the front door, then resumed.
        st = 7'd75;
        step();
        check("cool_on", 3'd6, O_COOL, 2'd2);
        sfd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("cool_fdoor%0d", i), 3'd1, O_FDOOR, 2'd2);
        end
        sfd = 1'b0;
        step();
        check("cool_resume", 3'd6, O_COOL, 2'd2);

        // Asynchronous reset between edges during ALARM.
        sfa = 1'b1;
        step();
        check("pre_reset_alarm", 3'd4, O_ALARM, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_alarm", 3'd0, O_NONE, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'b0000, 7'd60);
        step();
        check("post_reset_alarm", 3'd0, O_NONE, 2'd0);

        // Asynchronous reset during HEAT clears the climate mode too.
        st = 7'd48;
        step();
        check("pre_reset_heat", 3'd5, O_HEAT, 2'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_heat", 3'd0, O_NONE, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        st = 7'd51;
        step();
        check("post_reset_heat", 3'd0, O_NONE, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
